data_mem_bytelane: RTL and testbench



---
 rtl/data_mem_bytelane_pkg.sv | 32 +++
 rtl/data_mem_bytelane_if.sv | 25 ++
 rtl/data_mem_bytelane_load_formatter.sv | 24 ++
 rtl/data_mem_bytelane.sv | 89 ++++++++
 tb/tb_data_mem_bytelane.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/data_mem_bytelane_pkg.sv
// Shared encodings and byte-lane helpers for the byte-addressable data memory.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lane;
      SZ_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lane[0];
      SZ_WORD: misaligned = (lane != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_bytelane_if.sv
// Load/store request and response bundle between the LSU (master) and the data memory (slave).
interface data_mem_bytelane_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] A_in;
  logic [31:0]       D_in;
  logic              WE;
  logic              RE;
  logic [1:0]        size;
  logic              ld_unsigned;
  logic [31:0]       D_out;
  logic              D_valid;
  logic              ready;
  logic              err;

  modport master (
    output A_in, D_in, WE, RE, size, ld_unsigned,
    input  D_out, D_valid, ready, err
  );

  modport slave (
    input  A_in, D_in, WE, RE, size, ld_unsigned,
    output D_out, D_valid, ready, err
  );
endinterface

// File: rtl/data_mem_bytelane_load_formatter.sv
// Selects the addressed lane(s) of a memory word, right-justifies them and sign/zero extends.
module load_formatter
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: result = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
      SZ_WORD: result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_bytelane.sv
// Byte-lane data memory: sub-word stores, extended registered loads, error strobe and
// optional zero-fill sequencer that holds ready low after reset.
module data_mem_bytelane
  import data_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 256,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_bytelane_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t            state;
  logic [IDX_W-1:0]  clr_ptr;
  logic [31:0]       mem [DEPTH];

  logic              ready;
  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic              bad;
  logic              store_ok;
  logic              load_ok;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       ld_word;
  logic [31:0]       ld_result;

  assign ready     = (state == IDLE);
  assign bus.ready = ready;

  assign lane         = bus.A_in[1:0];
  assign word_idx     = bus.A_in >> 2;
  assign idx          = word_idx[IDX_W-1:0];
  assign out_of_range = ({1'b0, word_idx} >= (ADDR_W+1)'(DEPTH));
  assign bad          = misaligned(bus.size, lane) | out_of_range;

  assign store_ok = bus.WE & ready & ~bad;
  assign load_ok  = bus.RE & ready;
  assign be       = byte_en(bus.size, lane);
  assign wdata    = bus.D_in << {lane, 3'b000};
  assign ld_word  = mem[idx];

  load_formatter u_fmt (
    .word        (ld_word),
    .lane        (lane),
    .size        (bus.size),
    .ld_unsigned (bus.ld_unsigned),
    .result      (ld_result)
  );

  // Array has no reset; writes are held off while rst is high so that an
  // INIT_CLEAR=0 instance (IDLE during reset) cannot commit stray stores.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (store_ok) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT_CLEAR ? CLEAR : IDLE;
      clr_ptr     <= '0;
      bus.D_out   <= '0;
      bus.D_valid <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.D_valid <= load_ok;
      bus.err     <= (bus.WE | bus.RE) & ready & bad;
      if (load_ok) bus.D_out <= bad ? '0 : ld_result;
      if (state == CLEAR) begin
        if (clr_ptr == IDX_W'(DEPTH - 1)) state <= IDLE;
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Randomised and directed bench for data_mem_bytelane against a byte-array reference model.
module tb_data_mem_bytelane;
  import data_mem_pkg::*;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  data_mem_bytelane_if #(.ADDR_W(32)) bus ();

  data_mem_bytelane #(.ADDR_W(32), .DEPTH(DEPTH), .INIT_CLEAR(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state: memory as a flat byte array, clear progress as a countdown.
  logic [7:0]  ref_mem [DEPTH*4];
  int          clr_left = DEPTH;
  logic        chk_en    = 1'b0;
  logic        exp_ready = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_err   = 1'b0;
  logic [31:0] exp_dout  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("ready",   32'(bus.ready),   32'(exp_ready));
      check("D_valid", 32'(bus.D_valid), 32'(exp_valid));
      check("err",     32'(bus.err),     32'(exp_err));
      check("D_out",   bus.D_out,        exp_dout);
    end
  end

  function automatic logic is_bad(input logic [31:0] a, input logic [1:0] sz);
    return (sz == SZ_BAD) || (sz == SZ_HALF && (a % 2) != 0) ||
           (sz == SZ_WORD && (a % 4) != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] a, input logic [1:0] sz, input logic u);
    int unsigned v;
    logic [9:0]  ba;
    ba = a[9:0];
    v  = 0;
    case (sz)
      SZ_BYTE: begin
        v = 32'(ref_mem[ba]);
        if (!u && v >= 128) v = v - 256;
      end
      SZ_HALF: begin
        v = 32'(ref_mem[ba]) + 256 * 32'(ref_mem[ba + 10'd1]);
        if (!u && v >= 32768) v = v - 65536;
      end
      default: begin
        for (int k = 0; k < 4; k++) v = v + (32'(ref_mem[ba + 10'(k)]) << (8 * k));
      end
    endcase
    return v;
  endfunction

  task automatic issue(input logic r, input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic u);
    logic       b;
    logic [9:0] ba;
    @(negedge clk);
    rst = r;
    bus.WE = we; bus.RE = re; bus.A_in = a; bus.D_in = d; bus.size = sz; bus.ld_unsigned = u;
    chk_en = 1'b1;
    if (r) begin
      clr_left = DEPTH;
      foreach (ref_mem[i]) ref_mem[i] = 8'h00;
      exp_ready = 1'b0; exp_valid = 1'b0; exp_err = 1'b0; exp_dout = '0;
    end else if (clr_left > 0) begin
      clr_left--;
      exp_valid = 1'b0; exp_err = 1'b0;
      exp_ready = (clr_left == 0);
    end else begin
      b  = is_bad(a, sz);
      ba = a[9:0];
      exp_ready = 1'b1;
      exp_valid = re;
      exp_err   = (we || re) && b;
      if (re) exp_dout = b ? 32'h0 : load_value(a, sz, u);
      if (we && !b) begin
        ref_mem[ba] = d[7:0];
        if (sz != SZ_BYTE) ref_mem[ba + 10'd1] = d[15:8];
        if (sz == SZ_WORD) begin
          ref_mem[ba + 10'd2] = d[23:16];
          ref_mem[ba + 10'd3] = d[31:24];
        end
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD, 1'b0);
  endtask

  task automatic pin(input string name, input logic [31:0] lit);
    check({name, "_model"}, exp_dout, lit);
    check(name, bus.D_out, lit);
  endtask

  task automatic pin_flags(input string name, input logic v, input logic e);
    check({name, "_valid"}, 32'(bus.D_valid), 32'(v));
    check({name, "_err"},   32'(bus.err),     32'(e));
  endtask

  // Counts cycles after reset release until ready, throwing random requests at the clearing memory.
  task automatic measure_clear(input string name);
    int n;
    n = 0;
    do begin
      issue(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 1023)), $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      n++;
    end while (!bus.ready && n < 600);
    check(name, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    bus.WE = 1'b0; bus.RE = 1'b0; bus.A_in = '0; bus.D_in = '0;
    bus.size = SZ_WORD; bus.ld_unsigned = 1'b0;

    repeat (3) issue(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD, 1'b0);
    measure_clear("clear_len");

    issue(1'b0, 1'b0, 1'b1, 32'h0,   32'h0, SZ_WORD, 1'b0); pin("lw_w0", 32'h0);   pin_flags("lw_w0", 1'b1, 1'b0);
    issue(1'b0, 1'b0, 1'b1, 32'h3FC, 32'h0, SZ_WORD, 1'b0); pin("lw_w255", 32'h0); pin_flags("lw_w255", 1'b1, 1'b0);

    issue(1'b0, 1'b1, 1'b0, 32'h4, 32'h11223344, SZ_WORD, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 32'h6, 32'h000000AA, SZ_BYTE, 1'b0);
    issue(1'b0, 1'b0, 1'b1, 32'h4, 32'h0, SZ_WORD, 1'b0); pin("lw_4", 32'h11AA3344);
    issue(1'b0, 1'b0, 1'b1, 32'h6, 32'h0, SZ_BYTE, 1'b0); pin("lb_6", 32'hFFFFFFAA);
    issue(1'b0, 1'b0, 1'b1, 32'h6, 32'h0, SZ_BYTE, 1'b1); pin("lbu_6", 32'h000000AA);

    issue(1'b0, 1'b1, 1'b0, 32'h8, 32'h00008001, SZ_HALF, 1'b0);
    issue(1'b0, 1'b0, 1'b1, 32'h8, 32'h0, SZ_HALF, 1'b0); pin("lh_8", 32'hFFFF8001);
    issue(1'b0, 1'b0, 1'b1, 32'h8, 32'h0, SZ_HALF, 1'b1); pin("lhu_8", 32'h00008001);
    issue(1'b0, 1'b0, 1'b1, 32'hA, 32'h0, SZ_HALF, 1'b0); pin("lh_a", 32'h0);

    issue(1'b0, 1'b0, 1'b1, 32'h2, 32'h0, SZ_WORD, 1'b0); pin("lw_mis", 32'h0); pin_flags("lw_mis", 1'b1, 1'b1);
    issue(1'b0, 1'b1, 1'b0, 32'h5, 32'hFFFF, SZ_HALF, 1'b0); pin_flags("sh_mis", 1'b0, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 32'h4, 32'h0, SZ_WORD, 1'b0); pin("lw_4_kept", 32'h11AA3344);
    issue(1'b0, 1'b1, 1'b0, 32'h400, 32'h12345678, SZ_WORD, 1'b0); pin_flags("sw_oor", 1'b0, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, SZ_BAD, 1'b0); pin("sz11", 32'h0); pin_flags("sz11", 1'b1, 1'b1);

    issue(1'b0, 1'b1, 1'b1, 32'hC, 32'hDEADBEEF, SZ_WORD, 1'b0); pin("rw_first", 32'h0);
    issue(1'b0, 1'b0, 1'b1, 32'hC, 32'h0, SZ_WORD, 1'b0); pin("rw_after", 32'hDEADBEEF);
    idle(); pin_flags("idle", 1'b0, 1'b0); pin("hold", 32'hDEADBEEF);

    // Reset part-way through a fill, with requests arriving during both fills.
    repeat (2) issue(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD, 1'b0);
    repeat (100) issue(1'b0, 1'b1, 1'b1, 32'($urandom_range(0, 1023)), $urandom, SZ_BYTE, 1'b0);
    repeat (2) issue(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD, 1'b0);
    measure_clear("clear_restart");

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int unsigned k;
      k  = $urandom_range(0, 15);
      sz = 2'($urandom_range(0, 3));
      if (k == 0)      a = $urandom;
      else if (k == 1) a = 32'h400 + 32'($urandom_range(0, 64));
      else             a = 32'($urandom_range(0, 127));
      if (k > 3) begin
        if (sz == SZ_HALF) a = a & ~32'h1;
        if (sz == SZ_WORD) a = a & ~32'h3;
      end
      issue(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, sz,
            1'($urandom_range(0, 1)));
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
